beep_pattern_gen: RTL
=====================

// Module: beep_pattern_gen
// PURPOSE
// Multi-channel tone/cadence generator driving the speaker line. Each of N_CH requesters (ring, busy, record
// prompt, error) owns a pattern: tone half-period, on-time, off-time, repeat count. A fixed-priority arbiter
// picks one channel. That channel's pattern plays as a gated square wave on beep, with a per-channel done pulse.
// PARAMETERS
// CLK_HZ   100_000_000  system clock frequency; ms tick = TICK_CYC = CLK_HZ/1000 cycles (localparam)
// N_CH     4            number of requesting channels; channel 0 = highest priority
// DIV_W    20           width of tone half-period field (clk cycles)
// DUR_W    16           width of on/off time fields (ms)
// REP_W    8            width of repeat-count field
// PORTS
// clk       in   1              system clock, all logic on posedge
// rst       in   1              synchronous reset, active-high
// req       in   N_CH           level request per channel
// tone_div  in   N_CH*DIV_W     per-channel tone half-period in clk cycles (ch i at [i*DIV_W +: DIV_W])
// on_ms     in   N_CH*DUR_W     per-channel tone-on time, ms
// off_ms    in   N_CH*DUR_W     per-channel silence time, ms
// reps      in   N_CH*REP_W     per-channel on/off cycles; 0 = repeat while req held
// beep      out  1              gated square-wave speaker drive
// active    out  1              pattern in progress
// grant     out  N_CH           one-hot owner of the speaker while active; 0 when idle
// done      out  N_CH           1-cycle pulse: channel finished all reps
// BEHAVIOUR
// - Reset: state IDLE; beep, active, grant, done = 0; all counters 0; per-channel served bits cleared.
// - FSM IDLE -> ON -> OFF -> ON ...; exits to IDLE on completion or abort.
// - IDLE: eligible = req & ~served. Pick the lowest eligible index. Latch its tone_div/on_ms/off_ms/reps.
//   Next cycle: state ON, active=1, grant one-hot, beep=1 (1-cycle latency req->beep).
// - Config latched at accept; later input changes are ignored until the next accept.
// - ON: tone toggles every max(tone_div,1) cycles, starting high; beep = tone. ON lasts exactly
//   max(on_ms,1)*TICK_CYC cycles. The ms prescaler restarts at every phase entry, so timing is cycle-exact.
// - ON end: if off_ms==0, skip OFF and count one rep, back to ON (continuous tone). Else go to OFF.
//   In OFF, beep=0 for off_ms*TICK_CYC cycles, then one rep is counted.
// - After a counted rep: if reps!=0 and count==reps, then done[ch]=1 for one cycle and served[ch] is set.
//   State returns to IDLE with active, grant, beep = 0 on that same cycle. Otherwise the next ON starts.
// - reps==0: runs indefinitely; no done pulse.
// - Abort: active channel's req low in any cycle -> next cycle IDLE, beep/active/grant=0, no done.
// - served[i] clears when req[i] is low. A held req after done does not replay; drop and re-raise to rearm.
// - Back-to-back: a new accept can happen in the first IDLE cycle after completion (one idle cycle minimum).
// - Rep counter is REP_W bits and saturates; it never wraps while reps==0.
// - rst mid-pattern: immediate return to reset values on the next edge; no done pulse.
// CONFIGURATION
// BEEP_PREEMPT_EN defined: while active, an eligible channel with lower index than the owner preempts it.
//   Next cycle: the old owner is dropped without done (its served stays clear). The new config is latched,
//   state ON, tone restarts high, prescaler and rep count reset. The dropped channel resumes later only if
//   its req is still high and it is highest eligible.
// BEEP_PREEMPT_EN undefined: no preemption; the owner runs to completion or abort; higher requests wait in IDLE.
// TESTING (CLK_HZ=10_000 -> TICK_CYC=10; N_CH=4)
// 1 reset: assert rst 3 cycles with req=4'hF -> beep/active/grant/done all 0 throughout.
// 2 single: ch2 req, tone_div=2, on_ms=3, off_ms=2, reps=2 -> beep high 1 cycle after req.
//   Toggles every 2 cycles for 30 cycles, low 20, repeat; done[2] pulse at cycle 100; grant=4'b0100 meanwhile.
// 3 continuous: off_ms=0, reps=0, held 500 cycles -> unbroken toggling; drop req -> beep/active=0 next cycle, no done.
// 4 priority: req=4'b1010 in same cycle -> grant=4'b0010. After ch1 done and req[1] drop, ch3 accepted one cycle later.
// 5 preempt: ch3 active, raise req[0] -> EN: grant=4'b0001 next cycle, ch3 no done.
//   Not EN: ch3 finishes, done[3], then ch0 starts.
// 6 rearm: hold req[1] after done[1] for 200 cycles -> no replay. Low 1 cycle then high -> new pattern starts.

Source files
------------

// File: rtl/beep_pattern_gen_if.sv
// Speaker-pattern bus: per-channel requests and pattern configuration in,
// speaker drive and ownership/status out.
interface beep_pattern_gen_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DIV_W = 20,
  parameter int unsigned DUR_W = 16,
  parameter int unsigned REP_W = 8
);
  logic [N_CH-1:0]       req;
  logic [N_CH*DIV_W-1:0] tone_div;
  logic [N_CH*DUR_W-1:0] on_ms;
  logic [N_CH*DUR_W-1:0] off_ms;
  logic [N_CH*REP_W-1:0] reps;
  logic                  beep;
  logic                  active;
  logic [N_CH-1:0]       grant;
  logic [N_CH-1:0]       done;

  // Requesters drive patterns and observe the speaker status
  modport master (
    output req, tone_div, on_ms, off_ms, reps,
    input  beep, active, grant, done
  );

  // The generator consumes patterns and drives the speaker
  modport slave (
    input  req, tone_div, on_ms, off_ms, reps,
    output beep, active, grant, done
  );
endinterface

// File: rtl/beep_pattern_gen.sv
// Multi-channel tone/cadence generator. A fixed-priority arbiter (channel 0
// highest) selects one requester whose latched pattern plays as a gated square
// wave on beep: ON (tone) / OFF (silence) phases repeated reps times, then a
// one-cycle done pulse. Optional macro BEEP_PREEMPT_EN lets a higher-priority
// eligible request take over the speaker from the current owner.
module beep_pattern_gen #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DIV_W  = 20,
  parameter int unsigned DUR_W  = 16,
  parameter int unsigned REP_W  = 8
) (
  input logic               clk,
  input logic               rst,
  beep_pattern_gen_if.slave bus
);
  localparam int unsigned TICK_CYC = CLK_HZ / 1000;
  localparam int unsigned PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_owner;
  logic [N_CH-1:0]  r_grant;
  logic [N_CH-1:0]  r_done;
  logic [N_CH-1:0]  r_served;
  logic [DIV_W-1:0] r_div_m1;
  logic [DUR_W-1:0] r_on_m1;
  logic [DUR_W-1:0] r_off_m1;
  logic             r_off_zero;
  logic [REP_W-1:0] r_reps;
  logic [DIV_W-1:0] r_tone_cnt;
  logic             r_tone;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [DUR_W-1:0] r_ms_cnt;
  logic [REP_W-1:0] r_rep_cnt;

  logic [N_CH-1:0]  w_elig;
  logic             w_any;
  logic [IDX_W-1:0] w_pick_idx;
  logic [N_CH-1:0]  w_pick_oh;
  logic [DIV_W-1:0] w_cfg_div;
  logic [DUR_W-1:0] w_cfg_on;
  logic [DUR_W-1:0] w_cfg_off;
  logic [REP_W-1:0] w_cfg_reps;
  logic             w_preempt;
  logic             w_accept;
  logic             w_abort;
  logic             w_ms_end;
  logic             w_on_end;
  logic             w_off_end;
  logic             w_rep_evt;
  logic [REP_W-1:0] w_rep_next;
  logic             w_finish;
  logic             w_done_set;

  assign w_elig = bus.req & ~r_served;

  // Lowest-index eligible requester wins
  always_comb begin
    w_any      = 1'b0;
    w_pick_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_elig[i] && !w_any) begin
        w_any      = 1'b1;
        w_pick_idx = IDX_W'(i);
      end
    end
    w_pick_oh             = '0;
    w_pick_oh[w_pick_idx] = w_any;
  end

  assign w_cfg_div  = bus.tone_div[w_pick_idx*DIV_W +: DIV_W];
  assign w_cfg_on   = bus.on_ms[w_pick_idx*DUR_W +: DUR_W];
  assign w_cfg_off  = bus.off_ms[w_pick_idx*DUR_W +: DUR_W];
  assign w_cfg_reps = bus.reps[w_pick_idx*REP_W +: REP_W];

`ifdef BEEP_PREEMPT_EN
  assign w_preempt = (r_state != ST_IDLE) && w_any && (w_pick_idx < r_owner);
`else
  assign w_preempt = 1'b0;
`endif

  assign w_accept   = ((r_state == ST_IDLE) && w_any) || w_preempt;
  assign w_abort    = (r_state != ST_IDLE) && !bus.req[r_owner];
  assign w_ms_end   = (r_pre_cnt == PRE_LAST);
  assign w_on_end   = (r_state == ST_ON)  && w_ms_end && (r_ms_cnt == r_on_m1);
  assign w_off_end  = (r_state == ST_OFF) && w_ms_end && (r_ms_cnt == r_off_m1);
  assign w_rep_evt  = (w_on_end && r_off_zero) || w_off_end;
  assign w_rep_next = (r_rep_cnt == '1) ? r_rep_cnt : r_rep_cnt + 1'b1;
  assign w_finish   = w_rep_evt && (r_reps != '0) && (w_rep_next == r_reps);
  assign w_done_set = w_finish && !w_accept && !w_abort;

  // Pattern FSM, tone divider, ms prescaler and repeat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_div_m1   <= '0;
      r_on_m1    <= '0;
      r_off_m1   <= '0;
      r_off_zero <= 1'b0;
      r_reps     <= '0;
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
      r_pre_cnt  <= '0;
      r_ms_cnt   <= '0;
      r_rep_cnt  <= '0;
    end else begin
      r_done <= '0;
      if (w_accept) begin
        r_state    <= ST_ON;
        r_owner    <= w_pick_idx;
        r_grant    <= w_pick_oh;
        r_div_m1   <= (w_cfg_div == '0) ? '0 : w_cfg_div - 1'b1;
        r_on_m1    <= (w_cfg_on == '0) ? '0 : w_cfg_on - 1'b1;
        r_off_m1   <= w_cfg_off - 1'b1;
        r_off_zero <= (w_cfg_off == '0);
        r_reps     <= w_cfg_reps;
        r_tone     <= 1'b1;
        r_tone_cnt <= '0;
        r_pre_cnt  <= '0;
        r_ms_cnt   <= '0;
        r_rep_cnt  <= '0;
      end else if (w_abort || w_finish) begin
        r_state    <= ST_IDLE;
        r_grant    <= '0;
        r_tone     <= 1'b0;
        r_tone_cnt <= '0;
        r_pre_cnt  <= '0;
        r_ms_cnt   <= '0;
        r_rep_cnt  <= '0;
        if (w_done_set) r_done <= r_grant;
      end else if (r_state == ST_ON) begin
        if (r_tone_cnt == r_div_m1) begin
          r_tone_cnt <= '0;
          r_tone     <= ~r_tone;
        end else begin
          r_tone_cnt <= r_tone_cnt + 1'b1;
        end
        // With no OFF phase the tone keeps running across reps so the
        // continuous case has no phase glitch at rep boundaries.
        if (w_on_end) begin
          r_pre_cnt <= '0;
          r_ms_cnt  <= '0;
          if (r_off_zero) r_rep_cnt <= w_rep_next;
          else            r_state   <= ST_OFF;
        end else if (w_ms_end) begin
          r_pre_cnt <= '0;
          r_ms_cnt  <= r_ms_cnt + 1'b1;
        end else begin
          r_pre_cnt <= r_pre_cnt + 1'b1;
        end
      end else if (r_state == ST_OFF) begin
        if (w_off_end) begin
          r_state    <= ST_ON;
          r_tone     <= 1'b1;
          r_tone_cnt <= '0;
          r_pre_cnt  <= '0;
          r_ms_cnt   <= '0;
          r_rep_cnt  <= w_rep_next;
        end else if (w_ms_end) begin
          r_pre_cnt <= '0;
          r_ms_cnt  <= r_ms_cnt + 1'b1;
        end else begin
          r_pre_cnt <= r_pre_cnt + 1'b1;
        end
      end
    end
  end

  // Served bits block replay of a held request; cleared when req drops
  always_ff @(posedge clk) begin
    if (rst) r_served <= '0;
    else     r_served <= (r_served & bus.req) | (w_done_set ? r_grant : '0);
  end

  assign bus.beep   = (r_state == ST_ON) && r_tone;
  assign bus.active = (r_state != ST_IDLE);
  assign bus.grant  = r_grant;
  assign bus.done   = r_done;
endmodule
